csr_file_unit: RTL and testbench
================================

# csr_file_unit

Parametrised privileged CSR file for the core. It holds all M-mode and S-mode CSRs plus the user counter views, checks CSR access legality against the current privilege level, and sequences trap entry and `mret`/`sret` return. It owns the hart privilege level and sits beside the execute stage: the decoder drives CSR accesses, and the pipeline control consumes the trap redirect.

## Interface
- `XLEN`, 64: register width; 32 or 64.
- `HART_ID`, 0: value returned by `mhartid`.
- `RESET_MTVEC`, 0: reset value of `mtvec`.
- `MISA_VAL`, `64'h8000_0000_0014_1101`: read-only `misa` value, truncated to `XLEN`.
- `clk  in  1`: clock.
- `reset_n  in  1`: reset, asynchronous, active-low.
- `csr_valid  in  1`: CSR instruction present this cycle.
- `csr_op  in  2`: 01 RW, 10 RS, 11 RC; 00 is treated as no write.
- `csr_we  in  1`: write intended; the decoder clears it for RS/RC when rs1 is x0.
- `csr_addr  in  12`: CSR address.
- `csr_wdata  in  XLEN`: operand.
- `csr_rdata  out  XLEN`: old CSR value; combinational.
- `csr_illegal  out  1`: illegal access or illegal xRET; combinational.
- `pc  in  XLEN`: PC of the instruction in execute.
- `inst_retired  in  1`: one instruction retired.
- `exc_valid  in  1`: take a trap.
- `exc_interrupt  in  1`: the trap is an interrupt.
- `exc_cause  in  4`: cause code.
- `exc_tval  in  XLEN`: trap value.
- `mret`, `sret  in  1`: return instructions.
- `irq_mtip`, `irq_meip  in  1`: level interrupt lines, visible in `mip[7]` and `mip[11]`.
- `irq_pending  out  1`: an interrupt is enabled and pending.
- `irq_cause  out  4`: 11 if MEIP is pending, otherwise 7.
- `priv_lvl  out  2`: 00 U, 01 S, 11 M.
- `trap_taken  out  1`: one-cycle redirect pulse.
- `trap_pc  out  XLEN`: redirect target.

## Operation
- **Implemented CSRs:**
  - M-mode: `mstatus`, `misa`, `mhartid`, `mtvec`, `medeleg`, `mie`, `mip`, `mscratch`, `mepc`, `mcause`, `mtval`, `mcounteren`, `mcountinhibit`, `mcycle`, `minstret`.
  - S-mode: `sstatus`, `stvec`, `sscratch`, `sepc`, `scause`, `stval`.
  - User read-only views: `cycle`, `instret`.
- **`mstatus` WARL fields:**
  - Writable: SIE[1], MIE[3], SPIE[5], MPIE[7], SPP[8], MPP[12:11].
  - An MPP write of 10 is ignored.
  - All other bits read 0.
  - `sstatus` is a masked view of SIE, SPIE and SPP.
- **Illegal access** (`csr_valid` high) when any of:
  - `priv_lvl < addr[9:8]`;
  - `addr[9:8]` is 10;
  - unimplemented address;
  - `csr_we` high with `addr[11:10]` equal to 11;
  - `cycle` or `instret` read with `priv_lvl` below M and the matching `mcounteren` bit (0 or 2) clear.
- An illegal access causes no state change; `csr_rdata` is then 0.
- **Write value:** RW gives `wdata`; RS gives `old | wdata`; RC gives `old & ~wdata`.
- `mtvec` and `stvec` force bit 1 to 0.
- **Counters:**
  - `mcycle` increments every cycle unless `mcountinhibit[0]` is set.
  - `minstret` increments on `inst_retired` unless `mcountinhibit[2]` is set.
  - A CSR write to a counter in the same cycle wins over the increment.
  - Counters wrap at all-ones to 0.
- **Trap entry** (`exc_valid`):
  - Target is S if `priv_lvl` is not M and `medeleg[exc_cause]` is set; otherwise M.
  - Updates: `xepc`←`pc`; `xcause`←{`exc_interrupt`, zero-extended cause}; `xtval`←`exc_tval`; `xPIE`←`xIE`; `xIE`←0.
  - MPP←`priv_lvl` for M; SPP←`priv_lvl[0]` for S.
  - `priv_lvl`←target.
  - `trap_pc` = `xtvec` base, or base + 4·cause when `xtvec[0]` is set and `exc_interrupt` is high.
- **mret** (requires M):
  - `priv_lvl`←MPP; MIE←MPIE; MPIE←1; MPP←00.
  - `trap_pc`←`mepc`.
- **sret** (requires S or M):
  - `priv_lvl`←{0, SPP}; SIE←SPIE; SPIE←1; SPP←0.
  - `trap_pc`←`sepc`.
- An xRET issued below its required level asserts `csr_illegal` and changes no state.
- **`irq_pending`** = |(`mip` & `mie`) & (`priv_lvl` < M | MIE).
- **Priority in one cycle:** `exc_valid` > `mret`/`sret` > CSR write. A lower-priority event that loses is dropped.

## Timing
- Reads and `csr_illegal` are combinational in the same cycle.
- CSR writes become visible on the next edge.
- `trap_taken` and `trap_pc` are registered: they are valid in cycle N+1 for an `exc_valid`, `mret` or `sret` in cycle N. `trap_taken` lasts one cycle.
- The new `priv_lvl` is visible in cycle N+1.
- **Reset values:**
  - `priv_lvl`=11.
  - `mtvec`=`RESET_MTVEC`.
  - Every other CSR 0, except `misa` and `mhartid`, which are constants.
  - `trap_taken`=0, `trap_pc`=0.
  - `csr_rdata`, `irq_pending` and `csr_illegal` follow the reset state.
- Assertion of `reset_n` mid-trap aborts the pending redirect: no `trap_taken` pulse follows reset release.

## Structure
- Package `csr_pkg` holds:
  - CSR address constants;
  - privilege encodings;
  - `mstatus` bit positions;
  - CSR op encodings;
  - cause codes 3, 7, 11.
- Sub-module `csr_counter` (XLEN counter with increment enable, inhibit and write override) is instantiated for `mcycle` and `minstret`.

## Test plan
- Reset → `priv_lvl`=11, `mtvec` reads `RESET_MTVEC`, `trap_taken`=0. RS `mscratch` with `0xF0` and then RC with `0x30` → reads `0xC0`.
- In U mode, read `mstatus` → `csr_illegal`=1, `rdata`=0. Read `cycle` with `mcounteren`=0 → illegal; with `mcounteren`=1 → legal.
- `medeleg[8]`=1, U mode, `exc_valid` with cause 8 and `pc`=`0x1000`:
  - next cycle `trap_taken`=1, `trap_pc`=`stvec`, `priv_lvl`=01;
  - `sepc`=`0x1000`, SPP=0.
  - `sret` → `priv_lvl`=00 and `trap_pc`=`0x1000`.
- M mode with MIE=1, vectored `mtvec`=`0x201`, `mie[7]`=1, `irq_mtip`=1:
  - `irq_pending`=1, `irq_cause`=7;
  - on trap entry, `trap_pc`=`0x21C`, MIE=0, MPIE=1.
- Write `mcycle`=`0xFFFF_FFFF_FFFF_FFFF` → wraps to 0 on the following cycle. Setting `mcountinhibit`=5 freezes both counters.
- `exc_valid` and `mret` in the same cycle → trap entry only. `reset_n` low during that cycle → no `trap_taken` after release.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared constants for the privileged CSR file: addresses, privilege levels,
// mstatus field positions, CSR op encodings and interrupt cause codes.
package csr_pkg;

  typedef logic [1:0] priv_t;

  localparam priv_t PRIV_U = 2'b00;
  localparam priv_t PRIV_S = 2'b01;
  localparam priv_t PRIV_M = 2'b11;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  localparam logic [11:0] CSR_SSTATUS       = 12'h100;
  localparam logic [11:0] CSR_STVEC         = 12'h105;
  localparam logic [11:0] CSR_SSCRATCH      = 12'h140;
  localparam logic [11:0] CSR_SEPC          = 12'h141;
  localparam logic [11:0] CSR_SCAUSE        = 12'h142;
  localparam logic [11:0] CSR_STVAL         = 12'h143;
  localparam logic [11:0] CSR_MSTATUS       = 12'h300;
  localparam logic [11:0] CSR_MISA          = 12'h301;
  localparam logic [11:0] CSR_MEDELEG       = 12'h302;
  localparam logic [11:0] CSR_MIE           = 12'h304;
  localparam logic [11:0] CSR_MTVEC         = 12'h305;
  localparam logic [11:0] CSR_MCOUNTEREN    = 12'h306;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
  localparam logic [11:0] CSR_MEPC          = 12'h341;
  localparam logic [11:0] CSR_MCAUSE        = 12'h342;
  localparam logic [11:0] CSR_MTVAL         = 12'h343;
  localparam logic [11:0] CSR_MIP           = 12'h344;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_CYCLE         = 12'hC00;
  localparam logic [11:0] CSR_INSTRET       = 12'hC02;
  localparam logic [11:0] CSR_MHARTID       = 12'hF14;

  localparam int MSTATUS_SIE  = 1;
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_SPIE = 5;
  localparam int MSTATUS_MPIE = 7;
  localparam int MSTATUS_SPP  = 8;
  localparam int MSTATUS_MPP  = 11;

  localparam logic [3:0] CAUSE_MSI = 4'd3;
  localparam logic [3:0] CAUSE_MTI = 4'd7;
  localparam logic [3:0] CAUSE_MEI = 4'd11;

endpackage

// File: rtl/csr_file_unit_if.sv
// CSR access bus between the decoder (master) and the CSR file (slave).
interface csr_file_unit_if #(
  parameter int XLEN = 64
);
  logic            csr_valid;
  logic [1:0]      csr_op;
  logic            csr_we;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_illegal;

  modport master (
    output csr_valid, csr_op, csr_we, csr_addr, csr_wdata,
    input  csr_rdata, csr_illegal
  );

  modport slave (
    input  csr_valid, csr_op, csr_we, csr_addr, csr_wdata,
    output csr_rdata, csr_illegal
  );
endinterface

// File: rtl/csr_counter.sv
// Free-running XLEN counter with increment enable, inhibit and a write
// override that wins over the increment in the same cycle.
module csr_counter #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            inc_en,
  input  logic            inhibit,
  input  logic            we,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] value
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value <= '0;
    end else if (we) begin
      value <= wdata;
    end else if (inc_en && !inhibit) begin
      value <= value + {{(XLEN-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/csr_file_unit.sv
// Privileged M/S-mode CSR file: access legality, trap entry, xRET sequencing
// and ownership of the hart privilege level.
module csr_file_unit
  import csr_pkg::*;
#(
  parameter int          XLEN        = 64,
  parameter int unsigned HART_ID     = 0,
  parameter logic [63:0] RESET_MTVEC = 64'h0,
  parameter logic [63:0] MISA_VAL    = 64'h8000_0000_0014_1101
) (
  input  logic             clk,
  input  logic             reset_n,
  csr_file_unit_if.slave   csr_bus,
  input  logic [XLEN-1:0]  pc,
  input  logic             inst_retired,
  input  logic             exc_valid,
  input  logic             exc_interrupt,
  input  logic [3:0]       exc_cause,
  input  logic [XLEN-1:0]  exc_tval,
  input  logic             mret,
  input  logic             sret,
  input  logic             irq_mtip,
  input  logic             irq_meip,
  output logic             irq_pending,
  output logic [3:0]       irq_cause,
  output logic [1:0]       priv_lvl,
  output logic             trap_taken,
  output logic [XLEN-1:0]  trap_pc
);

  function automatic logic [XLEN-1:0] apply_op(input logic [1:0] op,
                                               input logic [XLEN-1:0] old,
                                               input logic [XLEN-1:0] opnd);
    case (op)
      CSR_OP_RS: return old | opnd;
      CSR_OP_RC: return old & ~opnd;
      default:   return opnd;
    endcase
  endfunction

  priv_t           priv_q;
  logic            st_sie, st_mie, st_spie, st_mpie, st_spp;
  logic [1:0]      st_mpp;
  logic [XLEN-1:0] mtvec_q, stvec_q, mie_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [XLEN-1:0] sscratch_q, sepc_q, scause_q, stval_q;
  logic [15:0]     medeleg_q;
  logic [2:0]      mcounteren_q, mcountinhibit_q;
  logic [XLEN-1:0] mcycle, minstret;
  logic            trap_vld_p1;
  logic [XLEN-1:0] trap_pc_p1;

  logic [11:0]     addr;
  logic [XLEN-1:0] mstatus_val, sstatus_val, mip_val, rd_val, wr_val, pend_vec;
  logic            implemented, ctr_denied, acc_illegal;
  logic            mret_ok, sret_ok, do_csr;
  logic            trap_to_s;
  logic [XLEN-1:0] tvec_sel, trap_target, trap_cause;

  assign addr = csr_bus.csr_addr;

  always_comb begin
    mstatus_val               = '0;
    mstatus_val[MSTATUS_SIE]  = st_sie;
    mstatus_val[MSTATUS_MIE]  = st_mie;
    mstatus_val[MSTATUS_SPIE] = st_spie;
    mstatus_val[MSTATUS_MPIE] = st_mpie;
    mstatus_val[MSTATUS_SPP]  = st_spp;
    mstatus_val[MSTATUS_MPP +: 2] = st_mpp;
    sstatus_val               = '0;
    sstatus_val[MSTATUS_SIE]  = st_sie;
    sstatus_val[MSTATUS_SPIE] = st_spie;
    sstatus_val[MSTATUS_SPP]  = st_spp;
    mip_val     = '0;
    mip_val[7]  = irq_mtip;
    mip_val[11] = irq_meip;
  end

  always_comb begin
    rd_val      = '0;
    implemented = 1'b1;
    case (addr)
      CSR_MSTATUS:       rd_val = mstatus_val;
      CSR_SSTATUS:       rd_val = sstatus_val;
      CSR_MISA:          rd_val = MISA_VAL[XLEN-1:0];
      CSR_MHARTID:       rd_val = XLEN'(HART_ID);
      CSR_MTVEC:         rd_val = mtvec_q;
      CSR_MEDELEG:       rd_val = {{(XLEN-16){1'b0}}, medeleg_q};
      CSR_MIE:           rd_val = mie_q;
      CSR_MIP:           rd_val = mip_val;
      CSR_MSCRATCH:      rd_val = mscratch_q;
      CSR_MEPC:          rd_val = mepc_q;
      CSR_MCAUSE:        rd_val = mcause_q;
      CSR_MTVAL:         rd_val = mtval_q;
      CSR_MCOUNTEREN:    rd_val = {{(XLEN-3){1'b0}}, mcounteren_q};
      CSR_MCOUNTINHIBIT: rd_val = {{(XLEN-3){1'b0}}, mcountinhibit_q};
      CSR_MCYCLE:        rd_val = mcycle;
      CSR_MINSTRET:      rd_val = minstret;
      CSR_CYCLE:         rd_val = mcycle;
      CSR_INSTRET:       rd_val = minstret;
      CSR_STVEC:         rd_val = stvec_q;
      CSR_SSCRATCH:      rd_val = sscratch_q;
      CSR_SEPC:          rd_val = sepc_q;
      CSR_SCAUSE:        rd_val = scause_q;
      CSR_STVAL:         rd_val = stval_q;
      default:           implemented = 1'b0;
    endcase
  end

  // User counter views need mcounteren permission below M.
  assign ctr_denied  = (priv_q != PRIV_M) &&
                       (((addr == CSR_CYCLE) && !mcounteren_q[0]) ||
                        ((addr == CSR_INSTRET) && !mcounteren_q[2]));
  assign acc_illegal = (priv_q < addr[9:8]) || (addr[9:8] == 2'b10) || !implemented ||
                       (csr_bus.csr_we && (addr[11:10] == 2'b11)) || ctr_denied;

  assign mret_ok = mret && (priv_q == PRIV_M);
  assign sret_ok = sret && (priv_q != PRIV_U);
  assign do_csr  = csr_bus.csr_valid && csr_bus.csr_we && (csr_bus.csr_op != CSR_OP_NONE) &&
                   !acc_illegal && !exc_valid && !mret_ok && !sret_ok;

  assign wr_val              = apply_op(csr_bus.csr_op, rd_val, csr_bus.csr_wdata);
  assign csr_bus.csr_rdata   = acc_illegal ? '0 : rd_val;
  assign csr_bus.csr_illegal = (csr_bus.csr_valid && acc_illegal) ||
                               (mret && !mret_ok) || (sret && !sret_ok);

  assign trap_to_s   = (priv_q != PRIV_M) && medeleg_q[exc_cause];
  assign tvec_sel    = trap_to_s ? stvec_q : mtvec_q;
  assign trap_target = {tvec_sel[XLEN-1:2], 2'b00} +
                       ((tvec_sel[0] && exc_interrupt) ?
                        {{(XLEN-6){1'b0}}, exc_cause, 2'b00} : '0);
  assign trap_cause  = {exc_interrupt, {(XLEN-5){1'b0}}, exc_cause};

  assign pend_vec    = mip_val & mie_q;
  assign irq_pending = (|pend_vec) && ((priv_q != PRIV_M) || st_mie);
  assign irq_cause   = pend_vec[11] ? CAUSE_MEI : CAUSE_MTI;

  csr_counter #(.XLEN(XLEN)) u_mcycle (
    .clk     (clk),
    .reset_n (reset_n),
    .inc_en  (1'b1),
    .inhibit (mcountinhibit_q[0]),
    .we      (do_csr && (addr == CSR_MCYCLE)),
    .wdata   (wr_val),
    .value   (mcycle)
  );

  csr_counter #(.XLEN(XLEN)) u_minstret (
    .clk     (clk),
    .reset_n (reset_n),
    .inc_en  (inst_retired),
    .inhibit (mcountinhibit_q[2]),
    .we      (do_csr && (addr == CSR_MINSTRET)),
    .wdata   (wr_val),
    .value   (minstret)
  );

  // Stage p1: trap entry / xRET / CSR write, one winner per cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      priv_q          <= PRIV_M;
      st_sie          <= 1'b0;
      st_mie          <= 1'b0;
      st_spie         <= 1'b0;
      st_mpie         <= 1'b0;
      st_spp          <= 1'b0;
      st_mpp          <= 2'b00;
      mtvec_q         <= RESET_MTVEC[XLEN-1:0];
      stvec_q         <= '0;
      mie_q           <= '0;
      mscratch_q      <= '0;
      mepc_q          <= '0;
      mcause_q        <= '0;
      mtval_q         <= '0;
      sscratch_q      <= '0;
      sepc_q          <= '0;
      scause_q        <= '0;
      stval_q         <= '0;
      medeleg_q       <= '0;
      mcounteren_q    <= '0;
      mcountinhibit_q <= '0;
      trap_vld_p1     <= 1'b0;
      trap_pc_p1      <= '0;
    end else begin
      trap_vld_p1 <= 1'b0;
      if (exc_valid) begin
        trap_vld_p1 <= 1'b1;
        trap_pc_p1  <= trap_target;
        if (trap_to_s) begin
          sepc_q   <= pc;
          scause_q <= trap_cause;
          stval_q  <= exc_tval;
          st_spie  <= st_sie;
          st_sie   <= 1'b0;
          st_spp   <= priv_q[0];
          priv_q   <= PRIV_S;
        end else begin
          mepc_q   <= pc;
          mcause_q <= trap_cause;
          mtval_q  <= exc_tval;
          st_mpie  <= st_mie;
          st_mie   <= 1'b0;
          st_mpp   <= priv_q;
          priv_q   <= PRIV_M;
        end
      end else if (mret_ok) begin
        trap_vld_p1 <= 1'b1;
        trap_pc_p1  <= mepc_q;
        priv_q      <= st_mpp;
        st_mie      <= st_mpie;
        st_mpie     <= 1'b1;
        st_mpp      <= PRIV_U;
      end else if (sret_ok) begin
        trap_vld_p1 <= 1'b1;
        trap_pc_p1  <= sepc_q;
        priv_q      <= {1'b0, st_spp};
        st_sie      <= st_spie;
        st_spie     <= 1'b1;
        st_spp      <= 1'b0;
      end else if (do_csr) begin
        case (addr)
          CSR_MSTATUS: begin
            st_sie  <= wr_val[MSTATUS_SIE];
            st_mie  <= wr_val[MSTATUS_MIE];
            st_spie <= wr_val[MSTATUS_SPIE];
            st_mpie <= wr_val[MSTATUS_MPIE];
            st_spp  <= wr_val[MSTATUS_SPP];
            if (wr_val[MSTATUS_MPP +: 2] != 2'b10) st_mpp <= wr_val[MSTATUS_MPP +: 2];
          end
          CSR_SSTATUS: begin
            st_sie  <= wr_val[MSTATUS_SIE];
            st_spie <= wr_val[MSTATUS_SPIE];
            st_spp  <= wr_val[MSTATUS_SPP];
          end
          CSR_MTVEC:         mtvec_q         <= {wr_val[XLEN-1:2], 1'b0, wr_val[0]};
          CSR_STVEC:         stvec_q         <= {wr_val[XLEN-1:2], 1'b0, wr_val[0]};
          CSR_MEDELEG:       medeleg_q       <= wr_val[15:0];
          CSR_MIE:           mie_q           <= {{(XLEN-12){1'b0}}, wr_val[11:0] & 12'hAAA};
          CSR_MSCRATCH:      mscratch_q      <= wr_val;
          CSR_MEPC:          mepc_q          <= wr_val;
          CSR_MCAUSE:        mcause_q        <= wr_val;
          CSR_MTVAL:         mtval_q         <= wr_val;
          CSR_MCOUNTEREN:    mcounteren_q    <= wr_val[2:0] & 3'b101;
          CSR_MCOUNTINHIBIT: mcountinhibit_q <= wr_val[2:0] & 3'b101;
          CSR_SSCRATCH:      sscratch_q      <= wr_val;
          CSR_SEPC:          sepc_q          <= wr_val;
          CSR_SCAUSE:        scause_q        <= wr_val;
          CSR_STVAL:         stval_q         <= wr_val;
          default: ;
        endcase
      end
    end
  end

  assign priv_lvl   = priv_q;
  assign trap_taken = trap_vld_p1;
  assign trap_pc    = trap_pc_p1;

endmodule

// File: tb/tb_csr_file_unit.sv
// Directed bench for csr_file_unit: legality, trap entry/return, interrupts,
// counters, event priority and reset abort of a pending redirect.
module tb_csr_file_unit;
  import csr_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] pc, exc_tval;
  logic        inst_retired, exc_valid, exc_interrupt, mret, sret, irq_mtip, irq_meip;
  logic [3:0]  exc_cause;
  logic        irq_pending, trap_taken;
  logic [3:0]  irq_cause;
  logic [1:0]  priv_lvl;
  logic [63:0] trap_pc;
  int          errors = 0;
  int          checks = 0;

  csr_file_unit_if #(.XLEN(64)) bus ();

  csr_file_unit #(
    .XLEN(64), .HART_ID(3), .RESET_MTVEC(64'h100)
  ) dut (
    .clk(clk), .reset_n(reset_n), .csr_bus(bus), .pc(pc), .inst_retired(inst_retired),
    .exc_valid(exc_valid), .exc_interrupt(exc_interrupt), .exc_cause(exc_cause),
    .exc_tval(exc_tval), .mret(mret), .sret(sret), .irq_mtip(irq_mtip), .irq_meip(irq_meip),
    .irq_pending(irq_pending), .irq_cause(irq_cause), .priv_lvl(priv_lvl),
    .trap_taken(trap_taken), .trap_pc(trap_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.csr_valid = 1'b0; bus.csr_op = 2'b00; bus.csr_we = 1'b0;
    bus.csr_addr = 12'h000; bus.csr_wdata = 64'h0;
    exc_valid = 1'b0; exc_interrupt = 1'b0; exc_cause = 4'd0; exc_tval = 64'h0;
    pc = 64'h0; mret = 1'b0; sret = 1'b0;
  endtask

  task automatic csr(input logic [1:0] op, input logic we, input logic [11:0] a, input logic [63:0] wd);
    bus.csr_valid = 1'b1; bus.csr_op = op; bus.csr_we = we;
    bus.csr_addr = a; bus.csr_wdata = wd;
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [63:0] v);
    csr(CSR_OP_RW, 1'b1, a, v);
    step();
    idle();
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a, input logic [63:0] exp);
    csr(CSR_OP_RS, 1'b0, a, 64'h0);
    check(tag, bus.csr_rdata, exp);
    idle();
  endtask

  task automatic take_exc(input logic intr, input logic [3:0] cause, input logic [63:0] epc,
                          input logic [63:0] tval);
    exc_valid = 1'b1; exc_interrupt = intr; exc_cause = cause; pc = epc; exc_tval = tval;
    step();
    idle();
  endtask

  initial begin
    reset_n = 1'b0; inst_retired = 1'b0; irq_mtip = 1'b0; irq_meip = 1'b0;
    idle();
    repeat (3) step();
    check("rst_priv", 64'(priv_lvl), 64'h3);
    check("rst_trap_taken", 64'(trap_taken), 64'h0);
    check("rst_trap_pc", trap_pc, 64'h0);
    reset_n = 1'b1;
    step();
    rd_chk("rst_mtvec", CSR_MTVEC, 64'h100);
    rd_chk("misa", CSR_MISA, 64'h8000_0000_0014_1101);
    rd_chk("mhartid", CSR_MHARTID, 64'h3);
    check("rst_irq_pending", 64'(irq_pending), 64'h0);

    // Set/clear on mscratch
    csr(CSR_OP_RS, 1'b1, CSR_MSCRATCH, 64'hF0);
    step();
    csr(CSR_OP_RC, 1'b1, CSR_MSCRATCH, 64'h30);
    check("rc_old_value", bus.csr_rdata, 64'hF0);
    step();
    idle();
    rd_chk("mscratch_rs_rc", CSR_MSCRATCH, 64'hC0);

    wr(CSR_MTVEC, 64'h203);
    rd_chk("mtvec_bit1", CSR_MTVEC, 64'h201);
    csr(CSR_OP_RW, 1'b1, CSR_MHARTID, 64'h5);
    check("ro_write_illegal", 64'(bus.csr_illegal), 64'h1);
    step();
    idle();
    rd_chk("mhartid_kept", CSR_MHARTID, 64'h3);
    wr(CSR_MSTATUS, 64'h1000);
    rd_chk("mpp10_ignored", CSR_MSTATUS, 64'h0);

    // mret into U
    wr(CSR_MEDELEG, 64'h100);
    wr(CSR_STVEC, 64'h802);
    rd_chk("stvec_bit1", CSR_STVEC, 64'h800);
    wr(CSR_MEPC, 64'h400);
    mret = 1'b1;
    step();
    idle();
    check("mret_taken", 64'(trap_taken), 64'h1);
    check("mret_pc", trap_pc, 64'h400);
    check("mret_priv", 64'(priv_lvl), 64'h0);
    step();
    check("taken_one_cycle", 64'(trap_taken), 64'h0);

    // U-mode legality
    csr(CSR_OP_RS, 1'b0, CSR_MSTATUS, 64'h0);
    check("u_mstatus_illegal", 64'(bus.csr_illegal), 64'h1);
    check("u_mstatus_rdata", bus.csr_rdata, 64'h0);
    idle();
    csr(CSR_OP_RS, 1'b0, CSR_CYCLE, 64'h0);
    check("u_cycle_denied", 64'(bus.csr_illegal), 64'h1);
    idle();
    csr(CSR_OP_RW, 1'b1, CSR_MSCRATCH, 64'hDEAD);
    step();
    idle();
    sret = 1'b1;
    #1;
    check("u_sret_illegal", 64'(bus.csr_illegal), 64'h1);
    step();
    idle();
    check("u_sret_no_trap", 64'(trap_taken), 64'h0);
    check("u_sret_priv", 64'(priv_lvl), 64'h0);

    // Delegated exception into S
    take_exc(1'b0, 4'd8, 64'h1000, 64'h55);
    check("deleg_taken", 64'(trap_taken), 64'h1);
    check("deleg_pc", trap_pc, 64'h800);
    check("deleg_priv", 64'(priv_lvl), 64'h1);
    rd_chk("sepc", CSR_SEPC, 64'h1000);
    rd_chk("scause", CSR_SCAUSE, 64'h8);
    rd_chk("stval", CSR_STVAL, 64'h55);
    rd_chk("sstatus_spp0", CSR_SSTATUS, 64'h0);
    mret = 1'b1;
    #1;
    check("s_mret_illegal", 64'(bus.csr_illegal), 64'h1);
    mret = 1'b0;
    sret = 1'b1;
    step();
    idle();
    check("sret_taken", 64'(trap_taken), 64'h1);
    check("sret_pc", trap_pc, 64'h1000);
    check("sret_priv", 64'(priv_lvl), 64'h0);

    // Non-delegated exception from U into M
    take_exc(1'b0, 4'd2, 64'h2000, 64'h0);
    check("m_trap_pc", trap_pc, 64'h200);
    check("m_trap_priv", 64'(priv_lvl), 64'h3);
    rd_chk("mcause", CSR_MCAUSE, 64'h2);
    rd_chk("mepc", CSR_MEPC, 64'h2000);
    rd_chk("mstatus_after_trap", CSR_MSTATUS, 64'h20);
    rd_chk("illegal_write_dropped", CSR_MSCRATCH, 64'hC0);

    // Counter access with mcounteren
    wr(CSR_MCOUNTEREN, 64'h1);
    wr(CSR_MEPC, 64'h3000);
    mret = 1'b1;
    step();
    idle();
    check("mret2_pc", trap_pc, 64'h3000);
    csr(CSR_OP_RS, 1'b0, CSR_CYCLE, 64'h0);
    check("u_cycle_allowed", 64'(bus.csr_illegal), 64'h0);
    idle();
    csr(CSR_OP_RS, 1'b0, CSR_INSTRET, 64'h0);
    check("u_instret_denied", 64'(bus.csr_illegal), 64'h1);
    idle();
    take_exc(1'b0, 4'd3, 64'h3004, 64'h0);
    check("back_to_m", 64'(priv_lvl), 64'h3);
    rd_chk("mstatus_round", CSR_MSTATUS, 64'h20);

    // Vectored timer interrupt
    csr(CSR_OP_RS, 1'b1, CSR_MSTATUS, 64'h8);
    step();
    idle();
    wr(CSR_MIE, 64'h80);
    irq_mtip = 1'b1;
    irq_meip = 1'b1;
    #1;
    check("irq_pending", 64'(irq_pending), 64'h1);
    check("irq_cause_mti", 64'(irq_cause), 64'h7);
    take_exc(1'b1, 4'd7, 64'h4000, 64'h0);
    check("vec_pc", trap_pc, 64'h21C);
    rd_chk("mstatus_irq", CSR_MSTATUS, 64'h18A0);
    rd_chk("mcause_irq", CSR_MCAUSE, 64'h8000_0000_0000_0007);
    check("irq_masked", 64'(irq_pending), 64'h0);
    wr(CSR_MIE, 64'h880);
    check("irq_cause_mei", 64'(irq_cause), 64'hB);
    irq_mtip = 1'b0;
    irq_meip = 1'b0;
    wr(CSR_MSTATUS, 64'h1000);
    rd_chk("mpp10_keeps_m", CSR_MSTATUS, 64'h1800);

    // Counters
    wr(CSR_MCYCLE, 64'hFFFF_FFFF_FFFF_FFFF);
    rd_chk("mcycle_written", CSR_MCYCLE, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    rd_chk("mcycle_wrap", CSR_MCYCLE, 64'h0);
    step();
    rd_chk("mcycle_after_wrap", CSR_MCYCLE, 64'h1);
    inst_retired = 1'b1;
    wr(CSR_MINSTRET, 64'hA);
    repeat (3) step();
    inst_retired = 1'b0;
    rd_chk("minstret_count", CSR_MINSTRET, 64'hD);
    wr(CSR_MCOUNTINHIBIT, 64'h5);
    wr(CSR_MCYCLE, 64'h50);
    wr(CSR_MINSTRET, 64'h60);
    inst_retired = 1'b1;
    repeat (4) step();
    inst_retired = 1'b0;
    rd_chk("mcycle_frozen", CSR_MCYCLE, 64'h50);
    rd_chk("minstret_frozen", CSR_MINSTRET, 64'h60);

    // Priority: exception beats mret and a CSR write
    exc_valid = 1'b1; exc_cause = 4'd3; pc = 64'h5000; mret = 1'b1;
    csr(CSR_OP_RW, 1'b1, CSR_MSCRATCH, 64'h77);
    step();
    idle();
    check("prio_pc", trap_pc, 64'h200);
    check("prio_taken", 64'(trap_taken), 64'h1);
    rd_chk("prio_mstatus", CSR_MSTATUS, 64'h1800);
    rd_chk("prio_mepc", CSR_MEPC, 64'h5000);
    rd_chk("prio_csr_dropped", CSR_MSCRATCH, 64'hC0);

    // Reset during a trap cycle aborts the redirect
    exc_valid = 1'b1; exc_cause = 4'd3; pc = 64'h6000; mret = 1'b1;
    #2;
    reset_n = 1'b0;
    step();
    idle();
    check("abort_in_reset", 64'(trap_taken), 64'h0);
    step();
    reset_n = 1'b1;
    step();
    check("abort_no_pulse", 64'(trap_taken), 64'h0);
    check("abort_priv", 64'(priv_lvl), 64'h3);
    rd_chk("abort_mtvec", CSR_MTVEC, 64'h100);
    rd_chk("abort_mscratch", CSR_MSCRATCH, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
